arbiter_burst_mux: RTL and testbench
====================================

Name: arbiter_burst_mux

Overview:
- Downstream consumer of the four-level round-robin arbiter's one-hot grants (gnt3..gnt0).
- Latches the granted requester's burst length and streams that requester's data beats onto one shared valid/ready output channel.
- Pulses a per-requester done when the burst completes, then holds off until the arbiter withdraws that grant. The requester must drop its req on done, which releases the arbiter's lock.

Parameters:
DW, 8, data width per requester and of the output channel
LW, 4, burst length field width; a burst is 1..(2^LW - 1) beats

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
gnt0..gnt3  input  1 each  one-hot grants from the arbiter
d0..d3  input  DW each  current data beat of each requester
len0..len3  input  LW each  burst length of each requester, sampled at grant
out_ready  input  1  downstream accepts beat
out_valid  output  1  beat valid
out_data  output  DW  beat data, equal to d[src]
out_src  output  2  index of the granted requester
out_last  output  1  final beat of the burst
ack  output  4  ack[i] pulses when a beat from requester i is accepted; requester i advances d_i
done  output  4  done[i] one-cycle pulse on burst completion or zero-length burst
err  output  1  sticky error flag; cleared only by rst

Behaviour:
- Reset (async, active-high): state=IDLE, src=0, cnt=0, err=0. out_valid, out_last, ack and done all 0.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - Form g={gnt3,gnt2,gnt1,gnt0}.
  - g==0: stay in IDLE.
  - g one-hot: src<=index, cnt<=len[index].
    - len!=0: go to XFER.
    - len==0: pulse done[index] in the next cycle and go to RELEASE; no beats are sent.
  - g has more than one bit set: err<=1, stay in IDLE, grant ignored.
- XFER:
  - Outputs: out_valid=1, out_data=d[src] (combinational mux from the registered src), out_src=src, out_last=(cnt==1).
  - First out_valid appears 1 cycle after the grant is sampled.
  - Beat accepted when out_valid & out_ready: ack[src]=1 that same cycle (combinational), cnt<=cnt-1.
  - Accept with cnt==1: done[src] registered pulse in the next cycle; go to RELEASE.
  - out_ready low: hold cnt and state; out_data tracks d[src], so the requester must hold d stable until ack.
- Grant lost mid-burst (gnt[src]==0 while in XFER): abort.
  - out_valid=0 from the next cycle, err<=1, no done pulse, go to IDLE.
  - If that same cycle has an accepted beat, the beat counts: ack pulses and cnt decrements.
- RELEASE:
  - out_valid=0.
  - Wait until gnt[src]==0, then go to IDLE.
  - Grants on other bits are ignored until then, which protects against the arbiter's registered grant lagging the req drop.
  - A new grant is sampled no earlier than the IDLE cycle after release.
- Back-to-back: the minimum gap between bursts is 2 idle output cycles (RELEASE then IDLE).
- Widths: cnt is LW bits and never wraps below 0. len sampling is unaffected by later changes to len_i.
- Synchronous behaviour is all on posedge clk; no other asynchronous paths.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, XFER=2'd1, RELEASE=2'd2), NREQ=4, SRC_W=2.
- One natural sub-module: arbiter_onehot_enc. It is combinational and maps the 4-bit grant to a 2-bit index plus a valid flag (exactly one bit set) and a multi-hot flag. It is reused by other arbiter consumers.
- Data and length muxes and the FSM stay in the top module.

Test Plan:
- Single burst: gnt1=1, len1=3, out_ready=1 → out_valid at cycles 1..3, out_src=1, out_last only on beat 3, ack[1] on 3 cycles, done[1]=1 at cycle 4, state RELEASE until gnt1 drops.
- Backpressure: gnt2=1, len2=2, out_ready toggled 1,0,0,1 → exactly 2 acks, out_data stable while stalled, done[2] after 2nd accept.
- Zero length: gnt0=1, len0=0 → no out_valid, done[0] pulse 1 cycle after grant, err=0.
- Mid-burst grant loss: gnt3=1, len3=5, gnt3 dropped after 2 accepts → out_valid falls next cycle, err=1, done stays 0, returns to IDLE and accepts gnt0 burst afterward.
- Multi-hot grant: gnt0=gnt2=1 in IDLE → no transfer, err=1 sticky until rst.
- Async reset mid-XFER: assert rst between clock edges → out_valid, ack, done drop immediately; after release, a fresh gnt1/len1=1 burst completes normally.

Source files
------------

// File: rtl/arbiter_burst_mux_pkg.sv
// Shared types and constants for the burst multiplexer and its one-hot grant encoder.
package arbiter_burst_mux_pkg;

  localparam int NREQ  = 4;
  localparam int SRC_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // One-hot vector with bit idx set; used for the per-requester ack/done lanes.
  function automatic logic [NREQ-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/arbiter_burst_mux_if.sv
// Grant/data inputs and the shared output stream of the burst multiplexer.
interface arbiter_burst_mux_if
  import arbiter_burst_mux_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
);

  logic             gnt0, gnt1, gnt2, gnt3;
  logic [DW-1:0]    d0, d1, d2, d3;
  logic [LW-1:0]    len0, len1, len2, len3;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [SRC_W-1:0] out_src;
  logic             out_last;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  done;
  logic             err;

  // Requester/arbiter/consumer side.
  modport master (
    output gnt0, gnt1, gnt2, gnt3,
    output d0, d1, d2, d3,
    output len0, len1, len2, len3,
    output out_ready,
    input  out_valid, out_data, out_src, out_last, ack, done, err
  );

  // Multiplexer side.
  modport slave (
    input  gnt0, gnt1, gnt2, gnt3,
    input  d0, d1, d2, d3,
    input  len0, len1, len2, len3,
    input  out_ready,
    output out_valid, out_data, out_src, out_last, ack, done, err
  );

endinterface

// File: rtl/arbiter_onehot_enc.sv
// Combinational grant encoder: 4-bit grant vector to index, exactly-one and multi-hot flags.
module arbiter_onehot_enc
  import arbiter_burst_mux_pkg::*;
(
  input  logic [NREQ-1:0]  g,
  output logic [SRC_W-1:0] idx,
  output logic             valid,
  output logic             multi
);

  logic [NREQ-1:0] g_low_cleared;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign g_low_cleared = g & (g - {{(NREQ-1){1'b0}}, 1'b1});
  assign multi         = |g_low_cleared;
  assign valid         = (|g) & ~multi;

  // Index of the highest set bit; only meaningful when valid is high.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) idx = SRC_W'(i);
    end
  end

endmodule

// File: rtl/arbiter_burst_mux.sv
// Streams the granted requester's burst onto one valid/ready channel and reports completion.
module arbiter_burst_mux
  import arbiter_burst_mux_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
)(
  input logic clk,
  input logic rst,
  arbiter_burst_mux_if.slave bus
);

  logic [NREQ-1:0]  g;
  logic [DW-1:0]    d_arr   [NREQ];
  logic [LW-1:0]    len_arr [NREQ];
  logic [SRC_W-1:0] g_idx;
  logic             g_valid;
  logic             g_multi;

  state_t           state;
  logic [SRC_W-1:0] src;
  logic [LW-1:0]    cnt;
  logic             valid_reg;
  logic [NREQ-1:0]  done_reg;
  logic             err_reg;

  logic             accept;
  logic             grant_held;
  logic             last_beat;

  assign g = {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};

  assign d_arr[0]   = bus.d0;
  assign d_arr[1]   = bus.d1;
  assign d_arr[2]   = bus.d2;
  assign d_arr[3]   = bus.d3;
  assign len_arr[0] = bus.len0;
  assign len_arr[1] = bus.len1;
  assign len_arr[2] = bus.len2;
  assign len_arr[3] = bus.len3;

  arbiter_onehot_enc u_enc (
    .g     (g),
    .idx   (g_idx),
    .valid (g_valid),
    .multi (g_multi)
  );

  assign accept     = valid_reg & bus.out_ready;
  assign grant_held = g[src];
  assign last_beat  = (cnt == LW'(1));

  // The output channel is driven from the registered source; data follows the live requester input.
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = d_arr[src];
  assign bus.out_src   = src;
  assign bus.out_last  = valid_reg & last_beat;
  assign bus.ack       = accept ? src_onehot(src) : '0;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;

  // Burst FSM: latch source and length at grant, count accepted beats, hold in RELEASE until the grant drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      cnt       <= '0;
      valid_reg <= 1'b0;
      done_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= '0;
      case (state)
        IDLE: begin
          if (g_multi) begin
            err_reg <= 1'b1;
          end else if (g_valid) begin
            src <= g_idx;
            cnt <= len_arr[g_idx];
            if (len_arr[g_idx] != '0) begin
              valid_reg <= 1'b1;
              state     <= XFER;
            end else begin
              // Zero-length burst: report completion without sending anything.
              done_reg <= src_onehot(g_idx);
              state    <= RELEASE;
            end
          end
        end

        XFER: begin
          if (!grant_held) begin
            // Grant withdrawn mid-burst: a beat accepted this cycle still counts, but no done.
            if (accept && cnt != '0) cnt <= cnt - LW'(1);
            valid_reg <= 1'b0;
            err_reg   <= 1'b1;
            state     <= IDLE;
          end else if (accept) begin
            cnt <= cnt - LW'(1);
            if (last_beat) begin
              valid_reg <= 1'b0;
              done_reg  <= src_onehot(src);
              state     <= RELEASE;
            end
          end
        end

        RELEASE: begin
          // Other grant bits are ignored here; the arbiter's registered grant may lag the req drop.
          if (!grant_held) state <= IDLE;
        end

        default: begin
          valid_reg <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_burst_mux.sv
// Directed scoreboard bench for arbiter_burst_mux: stimulus queues expected beats/done, a monitor checks them.
module tb_arbiter_burst_mux;

  typedef struct {
    logic [7:0] data;
    int         src;
    logic       last;
  } beat_t;

  logic clk;
  logic rst;

  arbiter_burst_mux_if #(.DW(8), .LW(4)) bus ();

  arbiter_burst_mux #(.DW(8), .LW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks;
  int    failures;
  beat_t exp_beats[$];
  int    exp_done[$];

  logic [7:0] d_base [4];
  logic [7:0] d_cnt  [4];
  logic [3:0] ack_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.d0 = d_base[0] + d_cnt[0];
  assign bus.d1 = d_base[1] + d_cnt[1];
  assign bus.d2 = d_base[2] + d_cnt[2];
  assign bus.d3 = d_base[3] + d_cnt[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [7:0] v);
    d_base[i] = v - d_cnt[i];
  endtask

  task automatic push_beat(input logic [7:0] data, input int src, input logic last);
    beat_t b;
    b.data = data;
    b.src  = src;
    b.last = last;
    exp_beats.push_back(b);
  endtask

  // Requester model: advance each requester's data after an accepted beat.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) d_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) if (ack_q[i]) d_cnt[i] <= d_cnt[i] + 8'd1;
    end
  end

  // Monitor: compare every presented beat and every done pulse against the scoreboard.
  always @(negedge clk) begin : monitor
    beat_t b;
    int    di;
    ack_q <= bus.ack;
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=data %0h src %0d required=no beat at %0t",
                   bus.out_data, bus.out_src, $time);
        end else begin
          b = exp_beats[0];
          chk("out_data", 32'(bus.out_data), 32'(b.data));
          chk("out_src",  32'(bus.out_src),  32'(b.src));
          chk("out_last", 32'(bus.out_last), 32'(b.last));
          if (bus.out_ready) begin
            chk("ack", 32'(bus.ack), 32'(1) << b.src);
            $display("beat src=%0d data=%0h last=%0b", bus.out_src, bus.out_data, bus.out_last);
            void'(exp_beats.pop_front());
          end
        end
      end else begin
        chk("ack_idle", 32'(bus.ack), 32'd0);
      end
      if (bus.done != 4'd0) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=0 at %0t", bus.done, $time);
        end else begin
          di = exp_done.pop_front();
          chk("done", 32'(bus.done), 32'(1) << di);
          $display("done src=%0d", di);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    {bus.gnt0, bus.gnt1, bus.gnt2, bus.gnt3} = 4'b0;
    bus.len0 = 4'd0; bus.len1 = 4'd0; bus.len2 = 4'd0; bus.len3 = 4'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d_base[i] = 8'd0;
    repeat (2) tick();

    // Reset state.
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_last",  32'(bus.out_last),  0);
    chk("rst_src",   32'(bus.out_src),   0);
    chk("rst_ack",   32'(bus.ack),       0);
    chk("rst_done",  32'(bus.done),      0);
    chk("rst_err",   32'(bus.err),       0);
    rst = 1'b0;
    tick();

    // Single burst: requester 1, three beats.
    set_d(1, 8'h10);
    bus.len1 = 4'd3; bus.gnt1 = 1'b1; bus.out_ready = 1'b1;
    push_beat(8'h10, 1, 1'b0); push_beat(8'h11, 1, 1'b0); push_beat(8'h12, 1, 1'b1);
    exp_done.push_back(1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(bus.out_valid), 1);
    end
    @(negedge clk);
    chk("t1_valid_end", 32'(bus.out_valid), 0);
    chk("t1_done",      32'(bus.done),      32'h2);
    @(negedge clk);
    chk("t1_release",   32'(bus.out_valid), 0);
    tick();
    bus.gnt1 = 1'b0;
    repeat (2) tick();

    // Backpressure: requester 2, two beats, ready 1,0,0,1.
    set_d(2, 8'h20);
    bus.len2 = 4'd2; bus.gnt2 = 1'b1;
    push_beat(8'h20, 2, 1'b0); push_beat(8'h21, 2, 1'b1);
    exp_done.push_back(2);
    tick();
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; tick();
    bus.out_ready = 1'b0; tick();
    bus.out_ready = 1'b1; tick();
    tick();
    bus.gnt2 = 1'b0;
    repeat (2) tick();

    // Zero-length burst on requester 0.
    bus.len0 = 4'd0; bus.gnt0 = 1'b1;
    exp_done.push_back(0);
    tick();
    @(negedge clk);
    chk("t3_done",  32'(bus.done),      32'h1);
    chk("t3_valid", 32'(bus.out_valid), 0);
    chk("t3_err",   32'(bus.err),       0);
    tick();
    bus.gnt0 = 1'b0;
    repeat (2) tick();

    // Multi-hot grant: ignored, sticky error.
    bus.gnt0 = 1'b1; bus.gnt2 = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_err",   32'(bus.err),       1);
    chk("t5_valid", 32'(bus.out_valid), 0);
    repeat (2) tick();
    chk("t5_valid_hold", 32'(bus.out_valid), 0);
    bus.gnt0 = 1'b0; bus.gnt2 = 1'b0;
    repeat (3) tick();
    chk("t5_err_sticky", 32'(bus.err), 1);
    rst = 1'b1;
    tick();
    chk("t5_err_cleared", 32'(bus.err), 0);
    rst = 1'b0;
    tick();

    // Grant lost mid-burst: requester 3, grant dropped during the second accepted beat.
    set_d(3, 8'h30);
    bus.len3 = 4'd5; bus.gnt3 = 1'b1; bus.out_ready = 1'b1;
    push_beat(8'h30, 3, 1'b0); push_beat(8'h31, 3, 1'b0);
    tick();
    tick();
    bus.gnt3 = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_valid", 32'(bus.out_valid), 0);
    chk("t4_err",   32'(bus.err),       1);
    chk("t4_done",  32'(bus.done),      0);
    tick();
    set_d(0, 8'h40);
    bus.len0 = 4'd2; bus.gnt0 = 1'b1;
    push_beat(8'h40, 0, 1'b0); push_beat(8'h41, 0, 1'b1);
    exp_done.push_back(0);
    repeat (5) tick();
    bus.gnt0 = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a burst, then a fresh single-beat burst.
    set_d(1, 8'h50);
    bus.len1 = 4'd3; bus.gnt1 = 1'b1; bus.out_ready = 1'b1;
    push_beat(8'h50, 1, 1'b0);
    tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_ack",   32'(bus.ack),       0);
    chk("t6_done",  32'(bus.done),      0);
    chk("t6_last",  32'(bus.out_last),  0);
    tick();
    rst = 1'b0;
    set_d(1, 8'h60);
    bus.len1 = 4'd1;
    push_beat(8'h60, 1, 1'b1);
    exp_done.push_back(1);
    repeat (3) tick();
    bus.gnt1 = 1'b0;
    repeat (2) tick();

    chk("beats_left", 32'(exp_beats.size()), 0);
    chk("done_left",  32'(exp_done.size()),  0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
